uart_rx_fifo: RTL

Synthesizable UART receiver with a small output FIFO. It is the DCE-facing receive end of the `uart_if` serial link, the counterpart of the transmit path driven by `uart_bfm`. It sits between the `rxd` line of a `uart_if` and an on-chip consumer such as a UART peripheral register block. It deserializes 8N1 frames, checks the stop bit, and presents bytes through a valid/ready interface.

---
 rtl/uart_rx_fifo.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// The line is synchronized, each frame is sampled mid-bit, and stop-bit faults are flagged.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_rxd,
    output logic [7:0]                      o_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
    output logic                            o_framing_err,
    output logic                            o_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bitn, bitn_next;
    logic [7:0]    shift, shift_next;
    logic          sync1, rxd_s;
    logic          good_stop, bad_stop;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   rd_ptr, wr_ptr, occupancy;
    logic          full, pop, push;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= i_rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            bitn  <= bitn_next;
            shift <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bitn_next  = bitn;
        shift_next = shift;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt == CNT_HALF) begin
                    if (rxd_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_next   = '0;
                        bitn_next  = '0;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    shift_next[bitn] = rxd_s;
                    cnt_next         = '0;
                    bitn_next        = bitn + 3'd1;
                    if (bitn == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_next = '0;
                    if (rxd_s) begin
                        good_stop  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == DEPTH_V);
    assign pop       = o_valid & i_ready;
    assign push      = good_stop & (~full | pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            o_framing_err <= 1'b0;
            o_overrun     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr              <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
            o_framing_err <= bad_stop;
            o_overrun     <= good_stop & full & ~pop;
        end
    end

    assign o_valid = (occupancy != '0);
    assign o_count = NW'(occupancy);
    assign o_data  = mem[rd_ptr[AW-1:0]];

endmodule
